// File: rtl/xps2_rx_pkg.sv
// Shared types and PS/2 frame constants for the PS/2 scan-code receiver.
// Frames are start + 8 data bits (LSB first) + odd parity + stop.
package xps2_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_CNT  = 3'd4
    } state_t;

    localparam int FRAME_BITS   = 11;
    localparam int PAYLOAD_BITS = FRAME_BITS - 1;
    localparam int CNT_W        = 16;

    // Payload layout after shifting: [7:0] data, [8] parity, [9] stop.
    function automatic logic frame_ok(input logic [PAYLOAD_BITS-1:0] payload);
        return (^payload[8:0]) & payload[9];
    endfunction

endpackage

// File: rtl/xps2_rx_xsync2.sv
// Two-flop synchronizer for one asynchronous PS/2 line; idles high like the bus.
module xsync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xps2_rx.sv
// PS/2 device-to-host receiver: validates frames, writes scan codes into a
// register-file ring and then updates a frame-count word.
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4,
    parameter int BUF_BASE    = 0,
    parameter int BUF_DEPTH   = 8,
    parameter int CNT_ADDR    = 15,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic                   ext_we,
    output logic [REGF_ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0]      ext_data_in,
    output logic                   busy,
    output logic                   err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    logic                    ps2_clk_s;
    logic                    ps2_data_s;
    logic                    ps2_clk_prev;
    logic                    fall;
    state_t                  state;
    state_t                  state_nxt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [3:0]              bit_idx;
    logic [WD_W-1:0]         wd;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        frame_cnt;
    logic                    we_nxt;
    logic [REGF_ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]       data_nxt;
    logic                    err_nxt;

    xsync2 u_sync_clk (
        .clk (clk),
        .rst (rst),
        .d   (ps2_clk),
        .q   (ps2_clk_s)
    );

    xsync2 u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (ps2_data),
        .q   (ps2_data_s)
    );

    assign fall = ps2_clk_prev & ~ps2_clk_s;

    // Edge-detect history and FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_prev <= 1'b1;
            state        <= ST_IDLE;
        end else begin
            ps2_clk_prev <= ps2_clk_s;
            state        <= state_nxt;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (!ps2_data_s) begin
                        state_nxt = ST_RECV;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (fall) begin
                    if (bit_idx == 4'(PAYLOAD_BITS - 1)) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_RECV;
                    end
                end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (frame_ok(shreg)) begin
                    state_nxt = ST_WR_DATA;
                    we_nxt    = 1'b1;
                    addr_nxt  = REGF_ADDR_W'(BUF_BASE) + REGF_ADDR_W'(wr_ptr);
                    data_nxt  = DATA_W'(shreg[7:0]);
                end else begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_WR_DATA: begin
                state_nxt = ST_WR_CNT;
                we_nxt    = 1'b1;
                addr_nxt  = REGF_ADDR_W'(CNT_ADDR);
                data_nxt  = DATA_W'(frame_cnt + 16'd1);
            end
            ST_WR_CNT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame datapath; wd counts cycles elapsed since the last PS/2 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_idx   <= '0;
            wd        <= '0;
            wr_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (fall) begin
                        shreg   <= {ps2_data_s, shreg[PAYLOAD_BITS-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        wd      <= WD_W'(1);
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_CHECK: begin
                    wd <= '0;
                end
                ST_WR_DATA: begin
                    wr_ptr    <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                    frame_cnt <= frame_cnt + 16'd1;
                end
                default: begin
                    shreg   <= '0;
                    bit_idx <= '0;
                    wd      <= '0;
                end
            endcase
        end
    end

    // Registered host write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_we      <= 1'b0;
            ext_addr    <= '0;
            ext_data_in <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ext_we      <= we_nxt;
            ext_addr    <= addr_nxt;
            ext_data_in <= data_nxt;
            busy        <= (state_nxt != ST_IDLE);
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_xps2_rx.sv
// Randomized self-checking bench for xps2_rx against a frame-level model
// (ring slot = ok-frame count mod depth, count word = ok-frame count + 1).
module tb_xps2_rx;

    localparam int DATA_W      = 32;
    localparam int REGF_ADDR_W = 4;
    localparam int BUF_BASE    = 0;
    localparam int BUF_DEPTH   = 8;
    localparam int CNT_ADDR    = 15;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ps2_clk = 1'b1;
    logic                   ps2_data = 1'b1;
    logic                   ext_we;
    logic [REGF_ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0]      ext_data_in;
    logic                   busy;
    logic                   err;

    xps2_rx #(
        .DATA_W      (DATA_W),
        .REGF_ADDR_W (REGF_ADDR_W),
        .BUF_BASE    (BUF_BASE),
        .BUF_DEPTH   (BUF_DEPTH),
        .CNT_ADDR    (CNT_ADDR),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_data_in (ext_data_in),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ok = 0;
    int          last_drop = 0;
    int          idle_bad = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          err_q[$];
    logic [31:0] mem_obs[16];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the host write port and err pulses away from the active edge.
    always @(negedge clk) begin
        if (ext_we) begin
            wq_addr.push_back(32'(ext_addr));
            wq_data.push_back(ext_data_in);
            wq_cyc.push_back(cyc);
            mem_obs[ext_addr] = ext_data_in;
        end else if (ext_addr != '0 || ext_data_in != '0) begin
            idle_bad++;
        end
        if (err) err_q.push_back(cyc);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        err_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_ok = 0;
    endtask

    // Drive the first nbits bits of a frame; last_drop = cycle of final falling edge.
    task automatic send_bits(input logic [7:0] b, input bit pflip, input bit stop_v, input int nbits);
        logic [10:0] fr;
        fr = {stop_v, (~^b) ^ pflip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            if (i == 1) chk_eq("busy_rx", 32'(busy), 32'd1);
            repeat (HALF) @(negedge clk);
            ps2_clk   = 1'b0;
            last_drop = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit pflip, input bit stop_v);
        bit ok;
        ok = !pflip && stop_v;
        send_bits(b, pflip, stop_v, 11);
        repeat (12) @(negedge clk);
        if (ok) begin
            chk_eq("wr_count", 32'(wq_addr.size()), 32'd2);
            if (wq_addr.size() == 2) begin
                chk_eq("data_addr", wq_addr[0], 32'(BUF_BASE + n_ok % BUF_DEPTH));
                chk_eq("data_word", wq_data[0], {24'h0, b});
                chk_eq("data_lat", 32'(wq_cyc[0]), 32'(last_drop + 4));
                chk_eq("cnt_addr", wq_addr[1], 32'(CNT_ADDR));
                chk_eq("cnt_word", wq_data[1], 32'((n_ok + 1) % 65536));
                chk_eq("cnt_lat", 32'(wq_cyc[1]), 32'(last_drop + 5));
            end
            chk_eq("err_none", 32'(err_q.size()), 32'd0);
            n_ok++;
        end else begin
            chk_eq("wr_none", 32'(wq_addr.size()), 32'd0);
            chk_eq("err_cnt", 32'(err_q.size()), 32'd1);
            if (err_q.size() == 1) chk_eq("err_lat", 32'(err_q[0]), 32'(last_drop + 4));
        end
        chk_eq("busy_idle", 32'(busy), 32'd0);
        clear_obs();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int kind;
        for (int i = 0; i < 16; i++) mem_obs[i] = 32'h0;

        // Reset state, sampled while rst is held.
        repeat (3) @(negedge clk);
        chk_eq("rst_we", 32'(ext_we), 32'd0);
        chk_eq("rst_addr", 32'(ext_addr), 32'd0);
        chk_eq("rst_data", ext_data_in, 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_obs();

        // Single valid frame 0x1C.
        run_frame(8'h1C, 1'b0, 1'b1);

        // Nine frames wrap the ring: 0x09 lands in slot 0.
        apply_reset();
        for (int i = 1; i <= 9; i++) run_frame(8'(i), 1'b0, 1'b1);
        chk_eq("wrap_slot0", mem_obs[BUF_BASE], 32'h9);
        chk_eq("wrap_cnt", mem_obs[CNT_ADDR], 32'h9);

        // Bad parity, then a good frame lands at slot 0 with count 1.
        apply_reset();
        clear_obs();
        run_frame(8'h1C, 1'b1, 1'b0 == 1'b0);
        run_frame(8'hA7, 1'b0, 1'b1);

        // Bad stop bit leaves the count alone.
        run_frame(8'h3E, 1'b0, 1'b0);
        run_frame(8'h5A, 1'b0, 1'b1);

        // Clock stops after four edges: watchdog fires.
        send_bits(8'h55, 1'b0, 1'b1, 4);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        chk_eq("to_err_cnt", 32'(err_q.size()), 32'd1);
        if (err_q.size() == 1) chk_eq("to_err_lat", 32'(err_q[0]), 32'(last_drop + 2 + TIMEOUT_CYC));
        chk_eq("to_wr_none", 32'(wq_addr.size()), 32'd0);
        chk_eq("to_busy", 32'(busy), 32'd0);
        clear_obs();
        run_frame(8'hC3, 1'b0, 1'b1);

        // Reset after the sixth data bit aborts silently.
        send_bits(8'hF0, 1'b0, 1'b1, 7);
        apply_reset();
        repeat (10) @(negedge clk);
        chk_eq("rm_wr_none", 32'(wq_addr.size()), 32'd0);
        chk_eq("rm_err_none", 32'(err_q.size()), 32'd0);
        chk_eq("rm_busy", 32'(busy), 32'd0);
        clear_obs();
        run_frame(8'h29, 1'b0, 1'b1);

        // Falling edge with data high while idle is a bad start bit.
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk   = 1'b0;
        last_drop = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        chk_eq("st_err_cnt", 32'(err_q.size()), 32'd1);
        if (err_q.size() == 1) chk_eq("st_err_lat", 32'(err_q[0]), 32'(last_drop + 3));
        chk_eq("st_wr_none", 32'(wq_addr.size()), 32'd0);
        clear_obs();

        // Random mix of good and corrupted frames.
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 9));
            run_frame(8'($urandom), kind == 7, kind != 8 && kind != 9);
        end

        chk_eq("idle_bus_zero", 32'(idle_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
